// File: rtl/count_mode_sequencer_pkg.sv
// Shared encodings for the counter-input select, the sequencer FSM and the
// mode-advance rule used by count_mode_sequencer.
package count_mode_sequencer_pkg;

    localparam int NUM_MODES = 5;

    typedef enum logic [2:0] {
        SEL_STOP = 3'd0,
        SEL_CLK  = 3'd1,
        SEL_ANY  = 3'd2,
        SEL_NEG  = 3'd3,
        SEL_POS  = 3'd4
    } selT;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SETTLE = 1'b1
    } stateT;

    // Out-of-range inputs fold back to STOP so the select can never exceed 4.
    function automatic selT nextMode(input selT mode);
        case (mode)
            SEL_STOP: return SEL_CLK;
            SEL_CLK:  return SEL_ANY;
            SEL_ANY:  return SEL_NEG;
            SEL_NEG:  return SEL_POS;
            default:  return SEL_STOP;
        endcase
    endfunction

endpackage

// File: rtl/count_mode_sequencer_if.sv
// Front-panel bundle: raw buttons and overflow in, mux select, clear and
// mode LEDs out. The sequencer takes the slave side.
interface count_mode_sequencer_if;
    import count_mode_sequencer_pkg::*;

    logic                 iBtnMode;
    logic                 iBtnClear;
    logic                 iOverflow;
    logic [2:0]           ovSel;
    logic                 oClear;
    logic [NUM_MODES-1:0] ovModeLeds;
    logic                 oBusy;

    modport master (
        output iBtnMode, iBtnClear, iOverflow,
        input  ovSel, oClear, ovModeLeds, oBusy
    );

    modport slave (
        input  iBtnMode, iBtnClear, iOverflow,
        output ovSel, oClear, ovModeLeds, oBusy
    );

endinterface

// File: rtl/count_mode_sequencer_button_debounce.sv
// Push-button front end: 2-flop synchronizer, stable-level debouncer and a
// registered one-cycle pulse on each accepted press.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20
) (
    input  logic iClk,
    input  logic iReset,
    input  logic iBtn,
    output logic oPress
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic            level;
    logic            levelDly;
    logic            armed;
    logic [1:0]      validPipe;
    logic [DB_W-1:0] dbCnt;

    // A button held through reset must be seen released before it can
    // produce a press; validPipe masks the reset zeros still in the
    // synchronizer so they do not count as a release.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            level     <= 1'b0;
            levelDly  <= 1'b0;
            armed     <= 1'b0;
            validPipe <= 2'b00;
            dbCnt     <= '0;
            oPress    <= 1'b0;
        end else begin
            sync1     <= iBtn;
            sync2     <= sync1;
            validPipe <= {validPipe[0], 1'b1};
            if (validPipe[1] && !sync2) begin
                armed <= 1'b1;
            end
            if (sync2 != level) begin
                if (dbCnt == DB_LAST) begin
                    level <= sync2;
                    dbCnt <= '0;
                end else begin
                    dbCnt <= dbCnt + DB_W'(1);
                end
            end else begin
                dbCnt <= '0;
            end
            levelDly <= level;
            oPress   <= level & ~levelDly & armed;
        end
    end

endmodule

// File: rtl/count_mode_sequencer.sv
// Counter-input mode sequencer with a STOP settle window on every change.
// Optional AUTOSTOP_EN: counter overflow forces the mode back to STOP.
//
// state     | meaning
// ST_RUN    | select drives the committed mode, MODE press starts a change
// ST_SETTLE | select held at STOP for SETTLE_CYCLES, then target committed
module count_mode_sequencer
    import count_mode_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20,
    parameter int SETTLE_CYCLES   = 2
) (
    input logic                  iClk,
    input logic                  iReset,
    count_mode_sequencer_if.slave bus
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    logic modePress;
    logic clearPress;
    logic ovfLive;

    stateT                state;
    stateT                stateNext;
    selT                  mode;
    selT                  modeNext;
    selT                  target;
    selT                  targetNext;
    logic [SW-1:0]        settleCnt;
    logic [SW-1:0]        cntNext;
    selT                  sel;
    selT                  selNext;
    logic                 busy;
    logic                 busyNext;
    logic                 clearReg;
    logic [NUM_MODES-1:0] leds;
    logic [NUM_MODES-1:0] ledsNext;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) uModeBtn (
        .iClk   (iClk),
        .iReset (iReset),
        .iBtn   (bus.iBtnMode),
        .oPress (modePress)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) uClearBtn (
        .iClk   (iClk),
        .iReset (iReset),
        .iBtn   (bus.iBtnClear),
        .oPress (clearPress)
    );

`ifdef AUTOSTOP_EN
    assign ovfLive = bus.iOverflow;
`else
    logic unusedOverflow;
    assign unusedOverflow = bus.iOverflow;
    assign ovfLive        = 1'b0;
`endif

    always_comb begin
        stateNext  = state;
        modeNext   = mode;
        targetNext = target;
        cntNext    = settleCnt;
        case (state)
            ST_RUN: begin
                // An overflow stop takes priority and swallows a coincident press.
                if (ovfLive && mode != SEL_STOP) begin
                    modeNext = SEL_STOP;
                end else if (modePress) begin
                    targetNext = nextMode(mode);
                    cntNext    = '0;
                    stateNext  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (ovfLive) begin
                    targetNext = SEL_STOP;
                end
                if (settleCnt == SETTLE_LAST) begin
                    modeNext  = targetNext;
                    stateNext = ST_RUN;
                end else begin
                    cntNext = settleCnt + SW'(1);
                end
            end
        endcase
        selNext  = (stateNext == ST_SETTLE) ? SEL_STOP : modeNext;
        busyNext = (stateNext == ST_SETTLE);
        ledsNext = NUM_MODES'(1) << modeNext;
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state     <= ST_RUN;
            mode      <= SEL_STOP;
            target    <= SEL_STOP;
            settleCnt <= '0;
            sel       <= SEL_STOP;
            busy      <= 1'b0;
            clearReg  <= 1'b0;
            leds      <= NUM_MODES'(1);
        end else begin
            state     <= stateNext;
            mode      <= modeNext;
            target    <= targetNext;
            settleCnt <= cntNext;
            sel       <= selNext;
            busy      <= busyNext;
            clearReg  <= clearPress;
            leds      <= ledsNext;
        end
    end

    assign bus.ovSel      = sel;
    assign bus.oClear     = clearReg;
    assign bus.ovModeLeds = leds;
    assign bus.oBusy      = busy;

endmodule

// File: tb/tb_count_mode_sequencer.sv
// Bench for count_mode_sequencer: directed steps plus random button traffic,
// checked against a cycle-indexed behavioural model of the front panel.
module tb_count_mode_sequencer;

    localparam int DB   = 4;
    localparam int SC   = 2;
    localparam int MAXC = 4096;
`ifdef AUTOSTOP_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic iClk   = 1'b0;
    logic iReset = 1'b0;

    count_mode_sequencer_if bus();

    count_mode_sequencer #(
        .DEBOUNCE_CYCLES (DB),
        .DB_W            (3),
        .SETTLE_CYCLES   (SC)
    ) dut (
        .iClk   (iClk),
        .iReset (iReset),
        .bus    (bus)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    // Model: raw samples per edge since reset, pending press events per edge.
    logic rawA  [2][MAXC+4];
    logic pendA [2][MAXC+4];
    logic accA  [2];
    int   t;
    int   mMode;
    int   mTarget;
    int   mSettle;
    logic mClear;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit allEq(input int b, input int lo, input int hi, input logic v);
        for (int k = lo; k <= hi; k++) begin
            if (rawA[b][k] !== v) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit anyLow(input int b, input int hi);
        for (int k = 1; k <= hi; k++) begin
            if (rawA[b][k] == 1'b0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic modelReset();
        t = 0;
        for (int b = 0; b < 2; b++) begin
            accA[b] = 1'b0;
            for (int k = 0; k < MAXC + 4; k++) begin
                rawA[b][k]  = 1'b0;
                pendA[b][k] = 1'b0;
            end
        end
        mMode = 0; mTarget = 0; mSettle = 0; mClear = 1'b0;
    endtask

    // Accepted level flips once the last DB synchronized samples all disagree
    // with it; a rising flip seen at edge n acts on the outputs at edge n+2.
    task automatic modelEdge(input logic m, input logic c, input logic o);
        t++;
        if (t > MAXC) begin
            $display("FAIL model_range observed %0d expected <= %0d", t, MAXC);
            errors++;
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "model history exhausted");
        end
        rawA[0][t] = m;
        rawA[1][t] = c;
        for (int b = 0; b < 2; b++) begin
            if (t - DB - 1 >= 1 && allEq(b, t - DB - 1, t - 2, ~accA[b])) begin
                accA[b] = ~accA[b];
                if (accA[b] && anyLow(b, t - 2)) pendA[b][t + 2] = 1'b1;
            end
        end
        mClear = pendA[1][t];
        if (mSettle > 0) begin
            if (OVF_EN && o) mTarget = 0;
            mSettle--;
            if (mSettle == 0) mMode = mTarget;
        end else if (OVF_EN && o && mMode != 0) begin
            mMode = 0;
        end else if (pendA[0][t]) begin
            mTarget = (mMode + 1) % 5;
            mSettle = SC;
        end
    endtask

    task automatic step(input logic m, input logic c, input logic o);
        bus.iBtnMode  = m;
        bus.iBtnClear = c;
        bus.iOverflow = o;
        @(posedge iClk);
        #1;
        modelEdge(m, c, o);
        chk("sel",   8'(bus.ovSel),      8'(mSettle > 0 ? 0 : mMode));
        chk("clear", 8'(bus.oClear),     8'(mClear));
        chk("leds",  8'(bus.ovModeLeds), 8'(1 << mMode));
        chk("busy",  8'(bus.oBusy),      8'(mSettle > 0));
    endtask

    task automatic cleanPress();
        for (int i = 1; i <= 16; i++) step(i <= 6, 1'b0, 1'b0);
    endtask

    int   busyCnt;
    int   seq [5];
    logic mBit, cBit;

    initial begin
        bus.iBtnMode  = 1'b0;
        bus.iBtnClear = 1'b0;
        bus.iOverflow = 1'b0;
        modelReset();

        // Asynchronous reset before the first clock edge.
        #2 iReset = 1'b1;
        #1;
        chk("rst_sel",   8'(bus.ovSel),      8'd0);
        chk("rst_clear", 8'(bus.oClear),     8'd0);
        chk("rst_leds",  8'(bus.ovModeLeds), 8'b00001);
        chk("rst_busy",  8'(bus.oBusy),      8'd0);
        @(posedge iClk); @(posedge iClk);
        #1 iReset = 1'b0;
        modelReset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);

        // Clean MODE press held 10 cycles.
        busyCnt = 0;
        for (int i = 1; i <= 30; i++) begin
            step(i <= 10, 1'b0, 1'b0);
            busyCnt += int'(bus.oBusy);
            if (i == 7)  chk("clean_pre",  8'(bus.ovSel), 8'd0);
            if (i == 8)  chk("clean_busy", 8'(bus.oBusy), 8'd1);
            if (i == 10) chk("clean_sel",  8'(bus.ovSel), 8'd1);
            if (i == 10) chk("clean_leds", 8'(bus.ovModeLeds), 8'b00010);
        end
        chk("clean_busy_len", 8'(busyCnt), 8'd2);

        // Bouncy press: high 3, low 1, then high 6 starting at i = 1.
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step(i <= 6, 1'b0, 1'b0);
            if (i == 7)  chk("bounce_hold", 8'(bus.ovSel), 8'd1);
            if (i == 8)  chk("bounce_drop", 8'(bus.ovSel), 8'd0);
            if (i == 10) chk("bounce_sel",  8'(bus.ovSel), 8'd2);
        end

        // MODE and CLEAR together in mode 2.
        for (int i = 1; i <= 20; i++) begin
            step(i <= 8, i <= 8, 1'b0);
            if (i == 8)  chk("both_clear",  8'(bus.oClear), 8'd1);
            if (i == 8)  chk("both_drop",   8'(bus.ovSel),  8'd0);
            if (i == 9)  chk("both_clear1", 8'(bus.oClear), 8'd0);
            if (i == 10) chk("both_sel",    8'(bus.ovSel),  8'd3);
        end

        // Reset mid-SETTLE with MODE held through reset.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0);
        chk("mid_busy", 8'(bus.oBusy), 8'd1);
        #2 iReset = 1'b1;
        #1;
        chk("mid_rst_sel",  8'(bus.ovSel),      8'd0);
        chk("mid_rst_leds", 8'(bus.ovModeLeds), 8'b00001);
        chk("mid_rst_busy", 8'(bus.oBusy),      8'd0);
        @(posedge iClk); @(posedge iClk);
        #1 iReset = 1'b0;
        modelReset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        chk("held_sel",  8'(bus.ovSel),      8'd0);
        chk("held_leds", 8'(bus.ovModeLeds), 8'b00001);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);

        // Five well-spaced presses walk the full cycle.
        seq = '{1, 2, 3, 4, 0};
        for (int k = 0; k < 5; k++) begin
            cleanPress();
            chk("walk_sel",  8'(bus.ovSel),      8'(seq[k]));
            chk("walk_leds", 8'(bus.ovModeLeds), 8'(1 << seq[k]));
        end

        // Overflow pulse in mode 4.
        for (int k = 0; k < 4; k++) cleanPress();
        chk("ovf_pre", 8'(bus.ovSel), 8'd4);
        step(1'b0, 1'b0, 1'b1);
        chk("ovf_sel",  8'(bus.ovSel),      OVF_EN ? 8'd0 : 8'd4);
        chk("ovf_leds", 8'(bus.ovModeLeds), OVF_EN ? 8'b00001 : 8'b10000);
        chk("ovf_busy", 8'(bus.oBusy),      8'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);

        // Random button traffic with occasional overflow pulses.
        for (int k = 0; k < 60; k++) begin
            mBit = 1'($urandom_range(0, 1));
            cBit = 1'($urandom_range(0, 1));
            for (int i = $urandom_range(1, 10); i > 0; i--)
                step(mBit, cBit, $urandom_range(0, 7) == 0);
            for (int i = $urandom_range(1, 10); i > 0; i--)
                step(~mBit, ~cBit, $urandom_range(0, 7) == 0);
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_mode_sequencer.md
# count_mode_sequencer

Front-panel controller for the 8-bit counter. It debounces the MODE and CLEAR push-buttons and steps the counter-input select through STOP → CLK → ANY-EDGE → NEG-EDGE → POS-EDGE → STOP. On every mode change it inserts a settle window with the select forced to STOP, so the input mux never switches directly between live sources. It drives the 3-bit select of the counter-input mux, a one-cycle counter clear, and one-hot mode LEDs.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a button level (10 ms at 50 MHz).
- DB_W, 20: debounce counter width; must satisfy 2^DB_W > DEBOUNCE_CYCLES.
- SETTLE_CYCLES, 2: cycles the select is held at STOP during a mode change; valid range ≥1.

Ports:
- iClk, in, 1: system clock; the only clock.
- iReset, in, 1: reset, asynchronous and active-high.
- iBtnMode, in, 1: raw MODE button, asynchronous, active-high.
- iBtnClear, in, 1: raw CLEAR button, asynchronous, active-high.
- iOverflow, in, 1: one-cycle pulse from the counter on wrap from 255 to 0.
- ovSel, out, 3: counter-input select: 0 STOP, 1 CLK, 2 ANY, 3 NEG, 4 POS.
- oClear, out, 1: one-cycle synchronous counter clear.
- ovModeLeds, out, 5: one-hot current mode; bit n lit when the mode encoding is n.
- oBusy, out, 1: high while in the SETTLE state.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer.
- The debouncer's accepted level changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- A registered press pulse fires for one cycle on each rising edge of the accepted level. Releases produce no action.
- FSM states:
  - RUN: ovSel = current mode.
    - MODE press: target = next(mode), go to SETTLE, settle counter cleared.
    - next(): 0→1→2→3→4→0.
  - SETTLE: ovSel = 0 and oBusy = 1.
    - After SETTLE_CYCLES cycles: mode = target, ovSel = target, go to RUN.
    - MODE presses in SETTLE are ignored; there is no queueing.
- ovModeLeds always reflects the committed mode, not the target.
- CLEAR press: oClear = 1 for exactly one cycle, in any state. It does not affect mode or FSM state.
- MODE and CLEAR pressed in the same cycle: both take effect independently.
- iOverflow is ignored unless AUTOSTOP_EN is defined.
- ovSel never presents an encoding above 4.

## Timing
- Reset values, asserted asynchronously: ovSel = 0, oClear = 0, ovModeLeds = 5'b00001, oBusy = 0. FSM in RUN, mode = STOP, synchronizers and debouncers at 0.
- Latency from the first iClk edge sampling a stable-high raw button:
  - synchronizer: 2 cycles.
  - debounce: DEBOUNCE_CYCLES.
  - press pulse: 1 cycle.
  - FSM/oClear register: 1 cycle.
  - Total: DEBOUNCE_CYCLES + 4 cycles until ovSel drops to 0 (MODE) or oClear asserts (CLEAR).
- ovSel shows the new mode exactly SETTLE_CYCLES cycles after dropping to 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset asserted mid-SETTLE: the pending target is discarded and the block returns to STOP in RUN.

## Configuration
- Macro AUTOSTOP_EN.
- Defined:
  - iOverflow in RUN with mode ≠ STOP: mode = STOP and ovSel = 0 on the next cycle, with no settle window.
  - iOverflow in SETTLE: target is replaced with STOP.
  - iOverflow coinciding with a MODE press in RUN: overflow wins, and the press is dropped.
- Not defined: iOverflow is unused and the counter wraps freely.

## Structure
- Shared package/include:
  - select encodings SEL_STOP, SEL_CLK, SEL_ANY, SEL_NEG, SEL_POS (3 bits).
  - FSM state encodings ST_RUN, ST_SETTLE.
  - next-mode function.
- One sub-module, button_debounce: synchronizer, debounce counter and rising-edge press pulse, parameterized by DEBOUNCE_CYCLES/DB_W. It is instantiated twice.
- The FSM, settle counter and output registers live in count_mode_sequencer.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, SETTLE_CYCLES=2.
- Reset: assert iReset mid-cycle → outputs immediately 0/0/5'b00001/0. Hold iBtnMode high through reset → no mode change until release and re-press.
- Clean MODE press held 10 cycles → ovSel 0 for cycles 8–9, ovSel = 1 from cycle 10, ovModeLeds = 5'b00010, oBusy high exactly 2 cycles.
- Bouncy MODE press (high 3, low 1, high 6) → exactly one advance, occurring 8 cycles after the final rising edge.
- Five clean presses, well spaced → ovSel sequence 1, 2, 3, 4, 0 with ovModeLeds tracking. A second press during SETTLE is ignored.
- MODE and CLEAR raw-high on the same cycle, in mode 2 → oClear single pulse and ovSel 0 in the same cycle, then ovSel = 3 two cycles later.
- AUTOSTOP_EN defined, mode 4, iOverflow pulse → ovSel = 0 and ovModeLeds = 5'b00001 next cycle, oBusy stays 0. Without the macro, the same pulse causes no change.
